// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory access controller
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mac_state_t;

  // Misaligned or reserved-size requests are rejected without touching memory
  function automatic logic access_err(input size_t size, input logic [OFF_W-1:0] off);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = (off != '0);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - big-endian lane extraction and sub-word merge for one memory word
module mem_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [31:0]      word,
  input  logic [OFF_W-1:0] off,
  input  size_t            size,
  input  logic             sgn,
  input  logic [31:0]      wdata,
  output logic [31:0]      load_val,
  output logic [31:0]      merged
);

  logic [4:0]  sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  // Shifting left by 8*off brings the addressed lane to the top of the word,
  // which is the most significant end in big-endian order
  always_comb begin
    sh        = {off, 3'b000};
    byte_lane = 8'((word << sh) >> 24);
    half_lane = 16'((word << sh) >> 16);
    lane_mask = 32'h0;
    lane_data = 32'h0;
    load_val  = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_val  = {{24{sgn & byte_lane[7]}}, byte_lane};
        lane_mask = 32'hFF00_0000 >> sh;
        lane_data = {wdata[7:0], 24'h0} >> sh;
        merged    = (word & ~lane_mask) | (lane_data & lane_mask);
      end
      SZ_HALF: begin
        load_val  = {{16{sgn & half_lane[15]}}, half_lane};
        lane_mask = 32'hFFFF_0000 >> sh;
        lane_data = {wdata[15:0], 16'h0} >> sh;
        merged    = (word & ~lane_mask) | (lane_data & lane_mask);
      end
      SZ_WORD: begin
        load_val = word;
        merged   = wdata;
      end
      default: begin
        load_val = word;
        merged   = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store initiator for the 32-bit data memory
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_data_out
);

  localparam int                CNT_W      = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(MEM_LAT - 1);

  mac_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             r_we;
  size_t            r_size;
  logic             r_sgn;
  logic [OFF_W-1:0] r_off;
  logic [31:0]      r_wdata;

  size_t            req_size;
  logic             req_err;
  logic [31:0]      load_val;
  logic [31:0]      merged;

  // Decode the incoming request for the accept decision
  always_comb begin
    req_size = size_t'(cpu_size);
    req_err  = access_err(req_size, cpu_addr[OFF_W-1:0]);
  end

  assign cpu_ready = ~rst && (state == IDLE);

  mem_lane_unit u_lane (
    .word     (mem_data_out),
    .off      (r_off),
    .size     (r_size),
    .sgn      (r_sgn),
    .wdata    (r_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  // Access sequencer: every memory phase is held MEM_LAT cycles by the wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_sgn       <= 1'b0;
      r_off       <= '0;
      r_wdata     <= 32'h0;
      cpu_rdata   <= 32'h0;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= 32'h0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
          if (cpu_valid) begin
            r_we    <= cpu_we;
            r_size  <= req_size;
            r_sgn   <= cpu_signed;
            r_off   <= cpu_addr[OFF_W-1:0];
            r_wdata <= cpu_wdata;
            cnt     <= CNT_RELOAD;
            if (req_err) begin
              state    <= RESP;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
            end else if (cpu_we && req_size == SZ_WORD) begin
              state       <= WRITE;
              mem_write   <= 1'b1;
              mem_address <= {cpu_addr[ADDR_W-1:2], 2'b00};
              mem_data_in <= cpu_wdata;
            end else begin
              state       <= READ;
              mem_read    <= 1'b1;
              mem_address <= {cpu_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            mem_read <= 1'b0;
            cnt      <= CNT_RELOAD;
            if (r_we) begin
              state       <= WRITE;
              mem_write   <= 1'b1;
              mem_data_in <= merged;
            end else begin
              state       <= RESP;
              cpu_done    <= 1'b1;
              cpu_rdata   <= load_val;
              mem_address <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            state       <= RESP;
            cnt         <= CNT_RELOAD;
            mem_write   <= 1'b0;
            cpu_done    <= 1'b1;
            mem_address <= '0;
            mem_data_in <= 32'h0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          cnt      <= CNT_RELOAD;
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl at MEM_LAT 1 and 3
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        cpu_valid    [2];
  logic        cpu_ready    [2];
  logic        cpu_we       [2];
  logic [1:0]  cpu_size     [2];
  logic        cpu_signed   [2];
  logic [5:0]  cpu_addr     [2];
  logic [31:0] cpu_wdata    [2];
  logic [31:0] cpu_rdata    [2];
  logic        cpu_done     [2];
  logic        cpu_err      [2];
  logic [5:0]  mem_address  [2];
  logic [31:0] mem_data_in  [2];
  logic        mem_read     [2];
  logic        mem_write    [2];
  logic [31:0] mem_data_out [2];

  mem_access_ctrl #(.ADDR_W(6), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .cpu_valid(cpu_valid[0]), .cpu_ready(cpu_ready[0]),
    .cpu_we(cpu_we[0]), .cpu_size(cpu_size[0]), .cpu_signed(cpu_signed[0]),
    .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]),
    .cpu_done(cpu_done[0]), .cpu_err(cpu_err[0]), .mem_address(mem_address[0]),
    .mem_data_in(mem_data_in[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_data_out(mem_data_out[0])
  );

  mem_access_ctrl #(.ADDR_W(6), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst[1]), .cpu_valid(cpu_valid[1]), .cpu_ready(cpu_ready[1]),
    .cpu_we(cpu_we[1]), .cpu_size(cpu_size[1]), .cpu_signed(cpu_signed[1]),
    .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]),
    .cpu_done(cpu_done[1]), .cpu_err(cpu_err[1]), .mem_address(mem_address[1]),
    .mem_data_in(mem_data_in[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_data_out(mem_data_out[1])
  );

  // Big-endian byte memories, one per DUT
  logic [7:0]  mem [2][64];
  logic        load_mem;
  logic [63:0] init_pat = 64'h1122_3384_5566_7788;

  assign mem_data_out[0] = {mem[0][mem_address[0]], mem[0][mem_address[0] + 6'd1],
                            mem[0][mem_address[0] + 6'd2], mem[0][mem_address[0] + 6'd3]};
  assign mem_data_out[1] = {mem[1][mem_address[1]], mem[1][mem_address[1] + 6'd1],
                            mem[1][mem_address[1] + 6'd2], mem[1][mem_address[1] + 6'd3]};

  // Memory model: preload the pattern, then take four-byte writes on memWrite
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load_mem) begin
        for (int i = 0; i < 64; i++)
          mem[d][i] <= (i < 8) ? init_pat[63 - 8*i -: 8] : 8'h00;
      end else if (mem_write[d]) begin
        mem[d][mem_address[d]]        <= mem_data_in[d][31:24];
        mem[d][mem_address[d] + 6'd1] <= mem_data_in[d][23:16];
        mem[d][mem_address[d] + 6'd2] <= mem_data_in[d][15:8];
        mem[d][mem_address[d] + 6'd3] <= mem_data_in[d][7:0];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [5:0]  addr;
    logic [31:0] wdat;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  int          cyc = 0;
  int          acc_cyc [2];
  int          rd_n    [2];
  int          wr_n    [2];
  logic [5:0]  st_addr [2];
  logic [31:0] st_wdat [2];
  bit          both_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count strobes per transaction and score each completion
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        rd_n[d] = 0;
        wr_n[d] = 0;
      end else begin
        if (mem_read[d]) begin
          rd_n[d]++;
          st_addr[d] = mem_address[d];
        end
        if (mem_write[d]) begin
          wr_n[d]++;
          st_addr[d] = mem_address[d];
          st_wdat[d] = mem_data_in[d];
        end
        if (mem_read[d] && mem_write[d]) both_seen = 1'b1;
        if (cpu_done[d]) begin
          if (sb_q.size() == 0 || sb_q[0].d != d) begin
            check_eq($sformatf("d%0d_spurious_done", d), 32'd1, 32'd0);
          end else begin
            mon_e = sb_q.pop_front();
            check_eq($sformatf("d%0d_rdata", d), cpu_rdata[d], mon_e.rdata);
            check_eq($sformatf("d%0d_err", d), 32'(cpu_err[d]), 32'(mon_e.err));
            check_eq($sformatf("d%0d_latency", d), cyc - acc_cyc[d], mon_e.lat);
            check_eq($sformatf("d%0d_read_cycles", d), rd_n[d], mon_e.rd_n);
            check_eq($sformatf("d%0d_write_cycles", d), wr_n[d], mon_e.wr_n);
            if (mon_e.rd_n + mon_e.wr_n > 0)
              check_eq($sformatf("d%0d_mem_addr", d), 32'(st_addr[d]), 32'(mon_e.addr));
            if (mon_e.wr_n > 0)
              check_eq($sformatf("d%0d_mem_wdata", d), st_wdat[d], mon_e.wdat);
          end
          rd_n[d] = 0;
          wr_n[d] = 0;
        end
      end
    end
  end

  task automatic issue(input int d, input bit push, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [5:0] a, input logic [31:0] wd,
                       input logic [31:0] x_rdata, input logic x_err, input int x_lat,
                       input int x_rd, input int x_wr, input logic [5:0] x_addr,
                       input logic [31:0] x_wdat);
    exp_t e;
    bit   ok;
    e.d = d; e.rdata = x_rdata; e.err = x_err; e.lat = x_lat;
    e.rd_n = x_rd; e.wr_n = x_wr; e.addr = x_addr; e.wdat = x_wdat;
    if (push) sb_q.push_back(e);
    @(posedge clk); #1;
    cpu_we[d] = we; cpu_size[d] = sz; cpu_signed[d] = sg;
    cpu_addr[d] = a; cpu_wdata[d] = wd; cpu_valid[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ready[d]) begin
        acc_cyc[d] = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_valid[d] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check_eq("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  int t1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cpu_valid[d] = 1'b0; cpu_we[d] = 1'b0; cpu_size[d] = 2'b00;
      cpu_signed[d] = 1'b0; cpu_addr[d] = 6'd0; cpu_wdata[d] = 32'h0;
    end
    load_mem = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("d%0d_ready_in_reset", d), 32'(cpu_ready[d]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0; load_mem = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_ready", d), 32'(cpu_ready[d]), 32'd1);
      check_eq($sformatf("d%0d_rst_rdata", d), cpu_rdata[d], 32'h0);
      check_eq($sformatf("d%0d_rst_done", d), 32'(cpu_done[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_err", d), 32'(cpu_err[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_strobes", d), 32'({mem_read[d], mem_write[d]}), 32'd0);
      check_eq($sformatf("d%0d_rst_addr", d), 32'(mem_address[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_din", d), mem_data_in[d], 32'h0);
    end

    // MEM_LAT=1 loads:   d push we sz  sg addr  wdata     rdata       err lat rd wr addr  wdat
    issue(0, 1, 0, 2'b10, 0, 6'd0, 32'h0, 32'h1122_3384, 0, 2, 1, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b00, 1, 6'd3, 32'h0, 32'hFFFF_FF84, 0, 2, 1, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b00, 0, 6'd3, 32'h0, 32'h0000_0084, 0, 2, 1, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b00, 1, 6'd1, 32'h0, 32'h0000_0022, 0, 2, 1, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b01, 1, 6'd2, 32'h0, 32'h0000_3384, 0, 2, 1, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b01, 0, 6'd0, 32'h0, 32'h0000_1122, 0, 2, 1, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b00, 1, 6'd7, 32'h0, 32'hFFFF_FF88, 0, 2, 1, 0, 6'd4, 32'h0);
    wait_idle();

    // Half store by read-modify-write, then read it back signed
    issue(0, 1, 1, 2'b01, 0, 6'd6, 32'h0000_ABCD, 32'hFFFF_FF88, 0, 3, 1, 1, 6'd4, 32'h5566_ABCD);
    wait_idle();
    check_eq("mem_4_7", {mem[0][4], mem[0][5], mem[0][6], mem[0][7]}, 32'h5566_ABCD);
    issue(0, 1, 0, 2'b01, 1, 6'd6, 32'h0, 32'hFFFF_ABCD, 0, 2, 1, 0, 6'd4, 32'h0);
    wait_idle();

    // Error requests: misaligned half, misaligned word store, reserved size
    issue(0, 1, 0, 2'b01, 0, 6'd5, 32'h0,         32'hFFFF_ABCD, 1, 1, 0, 0, 6'd0, 32'h0);
    issue(0, 1, 1, 2'b10, 0, 6'd2, 32'h1234_5678, 32'hFFFF_ABCD, 1, 1, 0, 0, 6'd0, 32'h0);
    issue(0, 1, 0, 2'b11, 0, 6'd0, 32'h0,         32'hFFFF_ABCD, 1, 1, 0, 0, 6'd0, 32'h0);
    wait_idle();

    // Word store goes straight to WRITE
    issue(0, 1, 1, 2'b10, 0, 6'd8, 32'hDEAD_BEEF, 32'hFFFF_ABCD, 0, 2, 0, 1, 6'd8, 32'hDEAD_BEEF);
    issue(0, 1, 0, 2'b10, 0, 6'd8, 32'h0,         32'hDEAD_BEEF, 0, 2, 1, 0, 6'd8, 32'h0);
    issue(0, 1, 0, 2'b00, 0, 6'd9, 32'h0,         32'h0000_00AD, 0, 2, 1, 0, 6'd8, 32'h0);
    wait_idle();
    @(negedge clk);
    check_eq("idle_addr", 32'(mem_address[0]), 32'd0);
    check_eq("idle_din", mem_data_in[0], 32'h0);

    // MEM_LAT=3: byte store then a queued word load
    issue(1, 1, 1, 2'b00, 0, 6'd0, 32'h0000_00EE, 32'h0, 0, 7, 3, 3, 6'd0, 32'hEE22_3384);
    t1 = acc_cyc[1];
    issue(1, 1, 0, 2'b10, 0, 6'd0, 32'h0, 32'hEE22_3384, 0, 4, 3, 0, 6'd0, 32'h0);
    check_eq("b2b_accept_gap", acc_cyc[1] - t1, 32'd8);
    wait_idle();

    // Reset during the second WRITE cycle of a MEM_LAT=3 word store
    issue(1, 0, 1, 2'b10, 0, 6'd8, 32'h1234_5678, 32'h0, 0, 0, 0, 0, 6'd0, 32'h0);
    @(posedge clk); #2;
    check_eq("pre_rst_mem_write", 32'(mem_write[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    check_eq("rst_mem_write", 32'(mem_write[1]), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read[1]), 32'd0);
    check_eq("rst_ready", 32'(cpu_ready[1]), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(cpu_ready[1]), 32'd1);
    repeat (10) @(negedge clk);

    check_eq("read_write_overlap", 32'(both_seen), 32'd0);
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
